mult_share_ctrl: RTL

Sequencer and two-way arbiter for the shared combinational array multiplier, the partial-product and carry-save reduction stages followed by the final adder. The block accepts operand pairs from two requesters and drives the chosen pair onto the multiplier inputs. It holds them stable for a programmed settle interval, since the gate-level array has multi-cycle propagation delay. It then captures the product and returns it tagged with the requester id. It sits between the execution-side requesters and the multiplier instance in the parent datapath.

---
 rtl/mult_share_pkg.sv | 17 +
 rtl/mult_share_ctrl_rr_arb2.sv | 19 +
 rtl/mult_share_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/mult_share_pkg.sv
// Shared types and constants for the multiplier sequencer/arbiter.
// The counter width helper keeps a 1-bit counter legal when the settle interval is 1.
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } mult_state_t;

    localparam int MULT_WIDTH = 6;

    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_arb2.sv
// Two-input round-robin grant: on contention the requester that was not
// served last (i_pointer) wins; a lone requester always wins.
module mult_share_ctrl_rr_arb2 (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_pointer,
    output logic o_grant0,
    output logic o_grant1,
    output logic o_grant_id
);

    logic w_pick1;

    assign w_pick1    = i_valid1 & (~i_valid0 | ~i_pointer);
    assign o_grant_id = w_pick1;
    assign o_grant0   = i_valid0 & ~w_pick1;
    assign o_grant1   = w_pick1;

endmodule

// File: rtl/mult_share_ctrl.sv
// Sequencer/arbiter for a shared multi-cycle combinational array multiplier.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int WIDTH         = MULT_WIDTH,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic               req1_valid,
    output logic               req0_ready,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_p,
    output logic               rsp_id,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    localparam int CW = cnt_width(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end

    mult_state_t        r_state;
    mult_state_t        w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic               r_ptr;
    logic               r_id;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic [2*WIDTH-1:0] r_rsp_p;
    logic               r_rsp_id;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_grant_id;
    logic               w_accept;

    mult_share_ctrl_rr_arb2 u_arb (
        .i_valid0   (req0_valid),
        .i_valid1   (req1_valid),
        .i_pointer  (r_ptr),
        .o_grant0   (w_grant0),
        .o_grant1   (w_grant1),
        .o_grant_id (w_grant_id)
    );

    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                req0_ready = w_grant0;
                req1_ready = w_grant1;
                if (w_grant0 | w_grant1) w_state_nxt = SETTLE;
            end
            SETTLE: if (r_cnt == '0) w_state_nxt = DONE;
            DONE:   if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = req0_ready | req1_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_ptr    <= 1'b1;
            r_id     <= 1'b0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_rsp_p  <= '0;
            r_rsp_id <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_mul_a <= w_grant_id ? req1_a : req0_a;
                r_mul_b <= w_grant_id ? req1_b : req0_b;
                r_id    <= w_grant_id;
                r_cnt   <= CNT_LOAD;
            end else if (r_state == SETTLE) begin
                // The array output is only trusted on the last settle cycle.
                if (r_cnt == '0) begin
                    r_rsp_p  <= mul_p;
                    r_rsp_id <= r_id;
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end
            if (r_state == DONE && rsp_ready) r_ptr <= r_id;
        end
    end

    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign rsp_valid = (r_state == DONE);
    assign rsp_p     = r_rsp_p;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

endmodule
